// File: rtl/rf_sched_pkg.sv
// Shared definitions for the register-file write-port scheduler.
package rf_sched_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int REG_COUNT = 32;
  localparam int ZERO_REG  = 0;
  localparam int DEF_AW    = 5;
  localparam int DEF_DW    = 32;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin priority picker: the first set request at or above the pointer
// wins; if none exists there, the search wraps to the lowest set request.
module rr_arbiter #(
  parameter int NREQ = 3,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [PW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [PW-1:0]   o_idx,
  output logic            o_any
);

  logic [NREQ-1:0] w_mask;
  logic [NREQ-1:0] w_masked;
  logic [PW-1:0]   w_m_idx;
  logic [PW-1:0]   w_u_idx;
  logic            w_m_hit;
  logic            w_u_hit;

  // Thermometer mask keeping only requesters at or above the pointer.
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_mask[k] = (PW'(k) >= i_ptr);
    end
  end

  assign w_masked = i_req & w_mask;

  // Lowest-index pick over the masked and unmasked request vectors.
  always_comb begin
    w_m_idx = '0;
    w_u_idx = '0;
    w_m_hit = 1'b0;
    w_u_hit = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_masked[k]) begin
        w_m_idx = PW'(k);
        w_m_hit = 1'b1;
      end
      if (i_req[k]) begin
        w_u_idx = PW'(k);
        w_u_hit = 1'b1;
      end
    end
  end

  // Prefer the masked pick so the search wraps only when nothing lies above.
  always_comb begin
    o_any = w_m_hit | w_u_hit;
    o_idx = w_m_hit ? w_m_idx : w_u_idx;
    o_gnt = o_any ? (NREQ'(1) << o_idx) : '0;
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Single write-port controller for the 32x32 register file: zero-fills
// registers 1..31 after reset, then round-robins writeback requesters.
// Writes to register 0 are accepted and discarded.
module rf_write_scheduler
  import rf_sched_pkg::*;
#(
  parameter int NREQ    = 3,
  parameter int AW      = DEF_AW,
  parameter int DW      = DEF_DW,
  parameter int INIT_EN = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_valid_i,
  input  logic [NREQ*AW-1:0] req_addr_i,
  input  logic [NREQ*DW-1:0] req_data_i,
  output logic [NREQ-1:0]    req_ready_o,
  input  logic               hold_i,
  output logic               wr_en_o,
  output logic [AW-1:0]      wr_addr_o,
  output logic [DW-1:0]      wr_data_o,
  output logic               init_done_o
);

  localparam int     PW        = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int     IW        = $clog2(REG_COUNT) + 1;
  localparam state_t RST_STATE = (INIT_EN != 0) ? INIT : RUN;

  state_t          r_state;
  logic [IW-1:0]   r_init_idx;
  logic [PW-1:0]   r_rr_ptr;
  logic            r_wr_en;
  logic [AW-1:0]   r_wr_addr;
  logic [DW-1:0]   r_wr_data;
  logic            r_init_done;

  state_t          w_state_nxt;
  logic [IW-1:0]   w_init_idx_nxt;
  logic [PW-1:0]   w_rr_ptr_nxt;
  logic            w_wr_en_nxt;
  logic [AW-1:0]   w_wr_addr_nxt;
  logic [DW-1:0]   w_wr_data_nxt;
  logic            w_init_done_nxt;

  logic [NREQ-1:0] w_zero;
  logic [NREQ-1:0] w_nz;
  logic [NREQ-1:0] w_gnt;
  logic [PW-1:0]   w_idx;
  logic            w_any;
  logic            w_run_act;
  logic            w_grant;
  logic [AW-1:0]   w_sel_addr;
  logic [DW-1:0]   w_sel_data;

  // Split valid requests into zero-address drops and real write candidates.
  always_comb begin
    w_zero = '0;
    w_nz   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_zero[k] = req_valid_i[k] && (req_addr_i[k*AW +: AW] == AW'(ZERO_REG));
      w_nz[k]   = req_valid_i[k] && (req_addr_i[k*AW +: AW] != AW'(ZERO_REG));
    end
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .i_req (w_nz),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign w_run_act   = (r_state == RUN) && !hold_i;
  assign w_grant     = w_run_act && w_any;
  assign req_ready_o = w_run_act ? (w_zero | w_gnt) : '0;
  assign w_sel_addr  = req_addr_i[32'(w_idx)*AW +: AW];
  assign w_sel_data  = req_data_i[32'(w_idx)*DW +: DW];

  // Next-state and next-output decode; write port defaults to idle.
  always_comb begin
    w_state_nxt     = r_state;
    w_init_idx_nxt  = r_init_idx;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_wr_en_nxt     = 1'b0;
    w_wr_addr_nxt   = r_wr_addr;
    w_wr_data_nxt   = r_wr_data;
    w_init_done_nxt = r_init_done;
    case (r_state)
      INIT: begin
        if (r_init_idx < IW'(REG_COUNT)) begin
          w_wr_en_nxt    = 1'b1;
          w_wr_addr_nxt  = AW'(r_init_idx);
          w_wr_data_nxt  = '0;
          w_init_idx_nxt = r_init_idx + IW'(1);
        end else begin
          w_state_nxt     = RUN;
          w_init_done_nxt = 1'b1;
        end
      end
      RUN: begin
        w_init_done_nxt = 1'b1;
        if (w_grant) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_addr_nxt = w_sel_addr;
          w_wr_data_nxt = w_sel_data;
          w_rr_ptr_nxt  = (w_idx == PW'(NREQ - 1)) ? '0 : w_idx + PW'(1);
        end
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  // State and registered write-port outputs; reset clears any in-flight write.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= RST_STATE;
      r_init_idx  <= IW'(1);
      r_rr_ptr    <= '0;
      r_wr_en     <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_init_done <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_init_idx  <= w_init_idx_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_wr_en     <= w_wr_en_nxt;
      r_wr_addr   <= w_wr_addr_nxt;
      r_wr_data   <= w_wr_data_nxt;
      r_init_done <= w_init_done_nxt;
    end
  end

  assign wr_en_o     = r_wr_en;
  assign wr_addr_o   = r_wr_addr;
  assign wr_data_o   = r_wr_data;
  assign init_done_o = r_init_done;

endmodule
